// File: rtl/idct_1d_if.sv
// Stream bundle for idct_1d: one coefficient in, one sample out per cycle, no backpressure.
interface idct_1d_if #(
   parameter int W_IN  = 12,
   parameter int W_OUT = 8
) ();
   logic                    in_valid;
   logic signed [W_IN-1:0]  in_coef;
   logic                    out_valid;
   logic signed [W_OUT-1:0] out_sample;

   modport master (output in_valid, output in_coef, input out_valid, input out_sample);
   modport slave  (input in_valid, input in_coef, output out_valid, output out_sample);
endinterface

// File: rtl/idct_1d.sv
// Streaming 8-point 1-D IDCT: eight parallel MACs over a constant cosine ROM, gapless 8-sample bursts.
// Define IDCT_1D_SAT_EN to saturate outputs; otherwise out-of-range results wrap. ROM values assume FRAC=12.
module idct_1d #(
   parameter int W_IN  = 12,
   parameter int W_OUT = 8,
   parameter int FRAC  = 12
) (
   input logic      clk,
   input logic      rst_n,
   idct_1d_if.slave bus
);
   localparam int W_ACC = W_IN + FRAC + 2;
   localparam int W_C   = FRAC + 1;
   localparam int W_SH  = W_ACC - FRAC;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_EMIT = 1'b1;

   // round(2^FRAC * 0.5 * cos(m*pi/16)) for m = 0..8
   function automatic int cos_base(input int m);
      case (m)
         0:       return 2048;
         1:       return 2009;
         2:       return 1892;
         3:       return 1703;
         4:       return 1448;
         5:       return 1138;
         6:       return 784;
         7:       return 400;
         default: return 0;
      endcase
   endfunction

   function automatic int coef(input int n, input int k);
      int m;
      if (k == 0) return 1448;
      m = ((2 * n + 1) * k) % 32;
      if (m <= 8)  return cos_base(m);
      if (m <= 16) return -cos_base(16 - m);
      if (m <= 24) return -cos_base(m - 16);
      return cos_base(32 - m);
   endfunction

   function automatic logic [64*W_C-1:0] build_rom();
      logic [64*W_C-1:0] r;
      r = '0;
      for (int n = 0; n < 8; n++)
         for (int k = 0; k < 8; k++)
            r[(n * 8 + k) * W_C +: W_C] = W_C'(coef(n, k));
      return r;
   endfunction

   localparam logic [64*W_C-1:0] C_ROM = build_rom();

   localparam logic signed [W_ACC-1:0] HALF  = W_ACC'(1) << (FRAC - 1);
   localparam logic signed [W_SH-1:0]  S_MAX = W_SH'((2 ** (W_OUT - 1)) - 1);
   localparam logic signed [W_SH-1:0]  S_MIN = W_SH'(-(2 ** (W_OUT - 1)));

   function automatic logic signed [W_OUT-1:0] post(input logic signed [W_ACC-1:0] v);
      logic signed [W_ACC-1:0] r;
      logic signed [W_SH-1:0]  s;
      r = v + HALF;
      s = W_SH'(r >>> FRAC);
`ifdef IDCT_1D_SAT_EN
      if (s > S_MAX) return W_OUT'(S_MAX);
      if (s < S_MIN) return W_OUT'(S_MIN);
      return W_OUT'(s);
`else
      return W_OUT'(s);
`endif
   endfunction

   logic [2:0]              k_q, k_d, cnt_q, cnt_d;
   logic [0:0]              st_q, st_d;
   logic signed [W_ACC-1:0] acc_q [8];
   logic signed [W_ACC-1:0] acc_d [8];
   logic signed [W_ACC-1:0] prod  [8];
   logic signed [W_ACC-1:0] sum   [8];
   logic signed [W_C-1:0]   c_sel [8];
   logic signed [W_OUT-1:0] ob_q  [8];
   logic signed [W_OUT-1:0] ob_d  [8];
   logic signed [W_OUT-1:0] ob_post [8];
   logic signed [W_OUT-1:0] out_sample_q, out_sample_d;
   logic signed [W_IN-1:0]  x_in;
   logic                    load;

   assign x_in = bus.in_coef;
   assign load = bus.in_valid && (k_q == 3'd7);

   always_comb begin
      k_d          = k_q;
      st_d         = st_q;
      cnt_d        = cnt_q;
      out_sample_d = out_sample_q;
      for (int n = 0; n < 8; n++) begin
         c_sel[n]   = $signed(C_ROM[(n * 8 + int'(k_q)) * W_C +: W_C]);
         prod[n]    = W_ACC'(c_sel[n]) * W_ACC'(x_in);
         sum[n]     = acc_q[n] + prod[n];
         ob_post[n] = post(sum[n]);
         acc_d[n]   = acc_q[n];
         ob_d[n]    = ob_q[n];
      end

      if (bus.in_valid) begin
         k_d = k_q + 3'd1;
         for (int n = 0; n < 8; n++)
            acc_d[n] = (k_q == 3'd0) ? prod[n] : sum[n];
      end

      // A load restarts the burst even on the edge that retires sample 7.
      if (load) begin
         for (int n = 0; n < 8; n++)
            ob_d[n] = ob_post[n];
         st_d         = ST_EMIT;
         cnt_d        = 3'd0;
         out_sample_d = ob_post[0];
      end else if (st_q == ST_EMIT) begin
         if (cnt_q == 3'd7) begin
            st_d = ST_IDLE;
         end else begin
            cnt_d        = cnt_q + 3'd1;
            out_sample_d = ob_q[cnt_q + 3'd1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         k_q          <= '0;
         st_q         <= ST_IDLE;
         cnt_q        <= '0;
         out_sample_q <= '0;
         for (int n = 0; n < 8; n++)
            acc_q[n] <= '0;
      end else begin
         k_q          <= k_d;
         st_q         <= st_d;
         cnt_q        <= cnt_d;
         out_sample_q <= out_sample_d;
         for (int n = 0; n < 8; n++)
            acc_q[n] <= acc_d[n];
      end
   end

   // Output bank is only read after a load writes it, so it needs no reset.
   always_ff @(posedge clk) begin
      for (int n = 0; n < 8; n++)
         ob_q[n] <= ob_d[n];
   end

   assign bus.out_valid  = (st_q == ST_EMIT);
   assign bus.out_sample = out_sample_q;
endmodule

// File: doc/idct_1d.md
# idct_1d

Streaming 8-point 1-D inverse DCT-II (IDCT): accepts one signed frequency coefficient per valid cycle and, after every 8 accepted coefficients, emits 8 reconstructed spatial samples on 8 consecutive cycles. It is the decoder-side counterpart of the forward row/column DCT stage. Two instances with a transpose buffer form the 2-D JPEG inverse transform. The block uses eight parallel multiply-accumulators fed by a constant cosine ROM, so it sustains one sample per cycle.

## Interface
- W_IN, 12: input coefficient width, signed two's complement.
- W_OUT, 8: output sample width, signed two's complement (no +128 level shift).
- FRAC, 12: fractional bits of the cosine constants.

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  in_coef is valid this cycle; there is no backpressure.
- in_coef  input  W_IN  coefficient X[k], presented in natural order k=0..7.
- out_valid  output  1  out_sample is valid.
- out_sample  output  W_OUT  reconstructed sample x[n], presented in order n=0..7.

## Operation
- Transform: x[n] = Σk C[n][k]·X[k].
  - C[n][k] = round(2^FRAC · ½·c(k)·cos((2n+1)kπ/16)).
  - c(0) = 1/√2; c(k>0) = 1.
  - The 64 constants are elaboration-time localparams, signed FRAC+1 bits.
- Input counter k (3 bits) advances only on in_valid and wraps 7→0.
- Accumulators acc[0..7] are signed W_IN+FRAC+2 bits.
  - Accepted coefficient with k=0: acc[n] ← C[n][0]·X.
  - Accepted coefficient with k=1..6: acc[n] ← acc[n] + C[n][k]·X.
- Accepted coefficient with k=7 (load event):
  - Each output bank entry ob[n] ← post(acc[n] + C[n][7]·X).
  - The output counter is set to 0 and the output phase starts.
- post() rounds half-up: add 2^(FRAC-1), arithmetic shift right by FRAC, then apply the width rule in Configuration.
- Output FSM, states IDLE and EMIT:
  - IDLE→EMIT on a load event.
  - In EMIT, one sample is presented per cycle; the output counter runs 0..7.
  - EMIT→IDLE after sample 7, unless a load event occurs on that same edge, in which case the FSM stays in EMIT with the counter reset to 0.
- No input stalls, and no other output-side events exist.
- Input and output phases are independent, so accumulation of block N+1 overlaps emission of block N.

## Timing
- Reset (rst_n=0 at a rising edge):
  - k=0, all acc=0, FSM=IDLE, out_valid=0, out_sample=0.
  - Any block being accumulated or emitted is discarded, with no partial output.
- Latency: x[0] appears in the cycle immediately after the edge that accepts X[7]. x[1..7] follow on the next 7 cycles with out_valid held high.
- Back-to-back blocks:
  - The earliest next load event is 8 edges after the previous one, which coincides with the edge after x[7] is presented.
  - Output is therefore gapless: 16 consecutive valid inputs produce 16 consecutive valid outputs.
- Gapped input: idle cycles do not reset k or acc. A block completes on its 8th accepted coefficient, however far apart the coefficients arrive.
- While out_valid=0, out_sample holds its last value; after reset that value is 0.
- in_valid asserted during the cycle rst_n=0 is ignored.

## Configuration
- IDCT_1D_SAT_EN defined: post() saturates the shifted result to [-2^(W_OUT-1), 2^(W_OUT-1)-1].
- IDCT_1D_SAT_EN undefined: post() keeps the low W_OUT bits, so out-of-range values wrap two's-complement.
- In-range results are identical with and without the macro.

## Test plan
- DC block X=[64,0,0,0,0,0,0,0] → x[0..7]=23 (C[n][0]=1448; 64·1448/4096=22.6 rounds to 23); out_valid high for exactly 8 cycles starting the cycle after X[7].
- X[1]=64, all others 0 → x = 31, 27, 18, 6, -6, -18, -27, -31.
- X[0]=2047, all others 0 → all eight samples = 127 with IDCT_1D_SAT_EN defined; -44 (724 wrapped) with it undefined.
- DC block from the first scenario with 1-3 idle cycles inserted between coefficients → outputs identical to the first scenario; out_valid begins the cycle after the 8th accepted coefficient.
- Two blocks (DC block, then the X[1] block) on 16 consecutive valid cycles → 16 consecutive out_valid cycles carrying both result sets in order.
- rst_n pulsed low after 5 coefficients of a block, then a fresh DC block is sent → no output from the aborted block; outputs = 23 ×8; out_valid=0 and out_sample=0 during and after reset until the new block completes.
